// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, round keys
// fetched by index from an external key store, plaintext returned with a done pulse.
module aes_inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] data_in,
  output logic [3:0]   rk_idx,
  input  logic [0:127] rk,
  output logic         busy,
  output logic         done,
  output logic [0:127] data_out
);
  localparam int unsigned BW = 128;
  localparam int unsigned RW = 4;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic [0:BW-1]   st_q, st_d;
  logic [0:BW-1]   dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [0:BW-1]   sub_ark;
  logic [0:BW-1]   mix_out;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    case (x)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte 4c+r is row r of column c; row r rotates right by r columns.
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return o;
  endfunction

  // Shared by ROUND (feeds InvMixColumns) and FINAL (feeds data_out).
  assign sub_ark = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk;

  inv_mix_columns u_inv_mix_columns (
    .data_i (sub_ark),
    .data_o (mix_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= IDLE;
      rnd_q  <= '0;
      st_q   <= '0;
      dout_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      st_q   <= st_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    st_d   = st_q;
    dout_d = dout_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rk_idx = RW'(NR);
    case (fsm_q)
      IDLE: begin
        rk_idx = RW'(NR);
        if (start) begin
          st_d   = data_in ^ rk;
          rnd_d  = RW'(NR - 1);
          busy_d = 1'b1;
          fsm_d  = ROUND;
        end
      end
      ROUND: begin
        rk_idx = rnd_q;
        st_d   = mix_out;
        rnd_d  = rnd_q - RW'(1);
        if (rnd_q == RW'(1)) fsm_d = FINAL;
      end
      FINAL: begin
        rk_idx = '0;
        dout_d = sub_ark;
        done_d = 1'b1;
        busy_d = 1'b0;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;
endmodule

// Combinational AES InvMixColumns over all four columns.
module inv_mix_columns (
  input  logic [0:127] data_i,
  output logic [0:127] data_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 0e/0b/0d/09 built from the x2, x4, x8 chain.
  function automatic logic [0:31] imix_col(input logic [0:31] col);
    logic [7:0] a [4];
    logic [7:0] m2, m4, m8;
    logic [7:0] me [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] m9 [4];
    logic [0:31] o;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*i +: 8];
      m2    = xt(a[i]);
      m4    = xt(m2);
      m8    = xt(m4);
      me[i] = m8 ^ m4 ^ m2;
      mb[i] = m8 ^ m2 ^ a[i];
      md[i] = m8 ^ m4 ^ a[i];
      m9[i] = m8 ^ a[i];
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      o[8*r +: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    return o;
  endfunction

  always_comb begin
    data_o = '0;
    for (int c = 0; c < 4; c++)
      data_o[32*c +: 32] = imix_col(data_i[32*c +: 32]);
  end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed and random checks of aes_inv_cipher_iter against a bench-side AES-128
// model and FIPS-197 vectors; the bench owns the key store.
module tb_aes_inv_cipher_iter;
  localparam int unsigned NR = 10;

  typedef struct {
    logic [0:127] key;
    logic [0:127] ct;
    logic [0:127] pt;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [0:127] data_in;
  logic [3:0]   rk_idx;
  logic [0:127] rk;
  logic         busy;
  logic         done;
  logic [0:127] data_out;

  logic [0:127] rk_mem [0:15];
  logic [7:0]   inv_tbl [0:255];
  logic [0:127] exp_out;
  int           n_chk  = 0;
  int           n_pass = 0;

  logic [0:2047] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  always #5 clk = ~clk;

  assign rk = rk_mem[rk_idx];

  aes_inv_cipher_iter #(.NR(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .rk_idx   (rk_idx),
    .rk       (rk),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_tbl[8*int'(x) +: 8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic load_keys(input logic [0:127] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]) ^ rcon, sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Forward cipher: an independent route back from plaintext to ciphertext.
  function automatic logic [0:127] encrypt(input logic [0:127] pt);
    logic [0:127] s, o;
    logic [7:0]   a [4];
    s = pt ^ rk_mem[0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) s[8*k +: 8] = sb(s[8*k +: 8]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      s = o;
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) a[i] = s[8*(4*c+i) +: 8];
          for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        s = o;
      end
      s = s ^ rk_mem[rd];
    end
    return s;
  endfunction

  function automatic logic [0:127] decrypt(input logic [0:127] ct);
    logic [0:127] s, o;
    logic [7:0]   a [4];
    s = ct ^ rk_mem[10];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
      for (int k = 0; k < 16; k++) s[8*k +: 8] = inv_tbl[o[8*k +: 8]];
      s = s ^ rk_mem[rd];
      if (rd != 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) a[i] = s[8*(4*c+i) +: 8];
          for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                              ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
        end
        s = o;
      end
    end
    return s;
  endfunction

  // Entered at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_block(input logic [0:127] ct, input logic [0:127] pt, input bit noise);
    chk("idle_rk_idx", 128'(rk_idx), 128'(NR));
    start   = 1'b1;
    data_in = ct;
    for (int k = 1; k <= NR + 1; k++) begin
      @(negedge clk);
      start   = 1'b0;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      if (noise && (k == 3 || k == 7)) begin
        start   = 1'b1;
        data_in = ~ct;
      end
      if (k <= NR) begin
        chk("busy_in_flight", 128'(busy), 128'(1));
        chk("done_early", 128'(done), 128'(0));
        chk("rk_idx_trace", 128'(rk_idx), 128'(NR - k));
        chk("data_out_hold", 128'(data_out), 128'(exp_out));
      end else begin
        chk("done_latency", 128'(done), 128'(1));
        chk("busy_cleared", 128'(busy), 128'(0));
        chk("data_out", 128'(data_out), 128'(pt));
        exp_out = pt;
      end
    end
    start = 1'b0;
  endtask

  vec_t vecs [3];
  logic [0:127] key, pt, ct, c1_key, c1_ct, c1_pt, b_ct;

  initial begin
    c1_key = 128'h000102030405060708090a0b0c0d0e0f;
    c1_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    c1_pt  = 128'h00112233445566778899aabbccddeeff;
    b_ct   = 128'h3925841d02dc09fbdc118597196a0b32;
    vecs[0] = '{key: c1_key, ct: c1_ct, pt: c1_pt};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: b_ct,
                pt: 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: 128'h0};

    for (int i = 0; i < 256; i++) inv_tbl[sb(8'(i))] = 8'(i);

    reset = 1'b1; start = 1'b0; data_in = '0; exp_out = '0;
    load_keys(c1_key);
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_data_out", 128'(data_out), 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(NR));
    reset = 1'b0;
    @(negedge clk);

    // Known-answer vectors, including a model self-check.
    for (int v = 0; v < 3; v++) begin
      load_keys(vecs[v].key);
      chk("model_encrypt", 128'(encrypt(vecs[v].pt)), 128'(vecs[v].ct));
      chk("model_decrypt", 128'(decrypt(vecs[v].ct)), 128'(vecs[v].pt));
      run_block(vecs[v].ct, vecs[v].pt, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", 128'(done), 128'(0));
    end

    // Back-to-back: second start lands in the done cycle of the first.
    load_keys(c1_key);
    run_block(c1_ct, c1_pt, 1'b0);
    run_block(b_ct, decrypt(b_ct), 1'b0);
    @(negedge clk);
    chk("b2b_done_one_cycle", 128'(done), 128'(0));

    // Starts while busy are ignored.
    run_block(c1_ct, c1_pt, 1'b1);
    @(negedge clk);

    // Reset mid-block aborts, ignoring a coincident start.
    start = 1'b1; data_in = c1_ct;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1; start = 1'b1; data_in = b_ct;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_data_out", 128'(data_out), 128'(0));
    chk("abort_rk_idx", 128'(rk_idx), 128'(NR));
    exp_out = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_done", 128'(done), 128'(0));
      chk("abort_idle", 128'(busy), 128'(0));
    end
    run_block(c1_ct, c1_pt, 1'b0);
    @(negedge clk);

    // Random keys and plaintexts, ciphertext from the forward model.
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_keys(key);
      ct = encrypt(pt);
      run_block(ct, pt, 1'b0);
    end
    @(negedge clk);
    chk("final_done_one_cycle", 128'(done), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 inverse cipher datapath: computes one decryption round per clock and instantiates the team's `InvMixColumns` block as its column-mixing stage. It accepts a 128-bit ciphertext and reads pre-expanded round keys one per cycle through an index/data port from the key store. It returns the 128-bit plaintext with a one-cycle `done` pulse. It sits between the decrypt request logic and the key store/output buffer.

## Interface
- `NR`, 10, number of rounds (AES-128); `rk_idx` width is fixed at 4 bits.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `data_in` input [0:127]: ciphertext, sampled in the `start` cycle.
- `rk_idx` output [3:0]: index of round key required this cycle (combinational from FSM/counter).
- `rk` input [0:127]: round key `rk_idx`, valid combinationally in the same cycle.
- `busy` output 1: registered, high while a block is in flight.
- `done` output 1: registered, one-cycle pulse, `data_out` valid.
- `data_out` output [0:127]: plaintext, holds until next completion.

## Operation
- Byte order: byte k = bits [8k:8k+7]; column c = bytes 4c..4c+3; byte 4c+r is row r.
- InvShiftRows: out(r,c) = in(r,(c−r) mod 4).
- InvSubBytes: 16 parallel inverse S-boxes, FIPS-197 inverse table, as a local 256-entry case function.
- AddRoundKey: XOR with `rk`.
- FSM states IDLE, ROUND, FINAL; 4-bit round counter `rnd`; 128-bit state register.
- IDLE: `rk_idx` = NR. If `start`: state ← `data_in` ^ `rk`, `rnd` ← NR−1, `busy` ← 1, go to ROUND. Otherwise hold.
- ROUND: `rk_idx` = `rnd`. State ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ `rk`), `rnd` ← `rnd`−1. If `rnd` = 1, go to FINAL.
- FINAL: `rk_idx` = 0. `data_out` ← InvSubBytes(InvShiftRows(state)) ^ `rk`, `done` ← 1, `busy` ← 0, go to IDLE.
- `done` is cleared in every cycle it is not set.
- `start` while `busy` is ignored, with no queuing.
- `start` in the `done` cycle is accepted, because the FSM is already in IDLE.
- InvMixColumns is purely combinational on the ROUND path and adds no latency.

## Timing
- Reset values: FSM IDLE, `rnd` 0, state 0, `busy` 0, `done` 0, `data_out` 0, so `rk_idx` = NR.
- Start accepted at cycle T.
  - `busy` is high T+1..T+NR.
  - ROUND occupies T+1..T+NR−1 with `rk_idx` = NR−1 down to 1.
  - FINAL occupies T+NR with `rk_idx` = 0.
  - `done` = 1 and new `data_out` appear at T+NR+1 (latency NR+1 = 11 cycles).
- Throughput: one block per NR+1 cycles with back-to-back `start`.
- Reset mid-operation aborts the block: no `done`, `data_out` ← 0, and the `start` asserted alongside `reset` is ignored.
- `rk_idx` sequence for one block: 10 (at T), 9, 8, …, 1, 0.
- `rk` must be stable within the cycle; the block never registers it.

## Test plan
- FIPS-197 C.1: bench key store holds the expansion of key 000102030405060708090a0b0c0d0e0f; `data_in` 69c4e0d86a7b0430d8cdb78070b4c55a -> `done` at T+11, `data_out` 00112233445566778899aabbccddeeff.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, `data_in` 3925841d02dc09fbdc118597196a0b32 -> `data_out` 3243f6a8885a308d313198a2e0370734. Also check the `rk_idx` trace 10,9,…,0 and that `busy` is high for exactly 10 cycles.
- Back-to-back: C.1 ciphertext, then `start` with the App. B ciphertext (same C.1 key store) asserted in the `done` cycle -> second `done` exactly 11 cycles later. `data_out` matches a reference model, and the first result holds in between.
- `start` pulsed at T+3 and T+7 with different `data_in` -> ignored; result and latency identical to the C.1 case.
- `reset` at T+5 -> next cycle `busy` 0, `done` never pulses, `data_out` 0, `rk_idx` 10. A new C.1 start afterwards completes correctly.
- Random: 1000 random key/ciphertext pairs against a software AES-128 model -> all `data_out` match, every `done` exactly one cycle wide.
